// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NREQ byte requesters.
// Sequences each grant as IDLE -> START -> BUSY -> ACK with a tx_done watchdog.
module uart_tx_arbiter #(
  parameter int unsigned DBITS   = 8,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DBITS-1:0]   din,
  output logic [NREQ-1:0]         ack,
  output logic                    tx_start,
  output logic [DBITS-1:0]        tx_din,
  input  logic                    tx_done,
  output logic                    busy,
  output logic [1:0]              grant_id,
  output logic                    timeout_err
);

  localparam int unsigned GW = 2;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [GW-1:0]     ptr;
  logic [GW-1:0]     ptr_nx;
  logic [TW-1:0]     timer;
  logic [TW-1:0]     timer_nx;
  logic [DBITS-1:0]  tx_din_nx;
  logic [GW-1:0]     grant_nx;
  logic [NREQ-1:0]   ack_nx;
  logic              tx_start_nx;
  logic              busy_nx;
  logic              timeout_nx;

  logic              found_c;
  logic [GW-1:0]     pick_c;
  int unsigned       idx_c;

  // Rotating-priority search: first set req bit at or above ptr, wrapping.
  always_comb begin
    found_c = 1'b0;
    pick_c  = ptr;
    idx_c   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx_c = (32'(ptr) + k) % NREQ;
      if (!found_c && req[idx_c]) begin
        found_c = 1'b1;
        pick_c  = GW'(idx_c);
      end
    end
  end

  // Next-state, holding registers and the registered output images.
  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    timer_nx   = timer;
    tx_din_nx  = tx_din;
    grant_nx   = grant_id;
    timeout_nx = 1'b0;

    case (state)
      IDLE: begin
        if (found_c) begin
          grant_nx  = pick_c;
          tx_din_nx = din[32'(pick_c)*DBITS +: DBITS];
          state_nx  = START;
        end
      end
      START: begin
        timer_nx = '0;
        state_nx = BUSY;
      end
      BUSY: begin
        // A completion landing on the last timer count still counts as normal.
        if (tx_done) begin
          state_nx = ACK;
        end else if (timer == TLAST) begin
          state_nx   = ACK;
          timeout_nx = 1'b1;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      ACK: begin
        ptr_nx   = GW'((32'(grant_id) + 1) % NREQ);
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    tx_start_nx = (state_nx == START);
    busy_nx     = (state_nx != IDLE);
    ack_nx      = (state_nx == ACK) ? (NREQ'(1) << grant_nx) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      timer       <= '0;
      tx_din      <= '0;
      grant_id    <= '0;
      ack         <= '0;
      tx_start    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      timer       <= timer_nx;
      tx_din      <= tx_din_nx;
      grant_id    <= grant_nx;
      ack         <= ack_nx;
      tx_start    <= tx_start_nx;
      busy        <= busy_nx;
      timeout_err <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: two instances (long and short watchdog),
// a transmitter model per instance, and one monitor that pops expectations on ack.
module tb_uart_tx_arbiter;

  typedef struct {
    logic [3:0] ack;
    logic [1:0] gid;
    logic [7:0] din;
    logic       to;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a = 1'b1;
  logic        reset_b = 1'b1;
  logic [3:0]  req_a, req_b, ack_a, ack_b;
  logic [31:0] din_a = '0;
  logic [31:0] din_b = '0;
  logic        tx_start_a, tx_start_b, tx_done_a, tx_done_b;
  logic [7:0]  tx_din_a, tx_din_b;
  logic        busy_a, busy_b, to_a, to_b;
  logic [1:0]  gid_a, gid_b;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  int raised_a[4] = '{0, 0, 0, 0};
  int acked_a[4]  = '{0, 0, 0, 0};
  int raised_b[4] = '{0, 0, 0, 0};
  int acked_b[4]  = '{0, 0, 0, 0};

  int   dly_a = 0, dly_b = 0, cnt_a = 0, cnt_b = 0;
  logic mdone_a = 1'b0, mdone_b = 1'b0, sdone_a = 1'b0;

  int cyc = 0, st_a = 0, st_b = 0;
  exp_t em;

  uart_tx_arbiter #(.DBITS(8), .NREQ(4), .TIMEOUT(4096)) dut_a (
    .clk(clk), .reset(reset_a), .req(req_a), .din(din_a), .ack(ack_a),
    .tx_start(tx_start_a), .tx_din(tx_din_a), .tx_done(tx_done_a),
    .busy(busy_a), .grant_id(gid_a), .timeout_err(to_a)
  );

  uart_tx_arbiter #(.DBITS(8), .NREQ(4), .TIMEOUT(16)) dut_b (
    .clk(clk), .reset(reset_b), .req(req_b), .din(din_b), .ack(ack_b),
    .tx_start(tx_start_b), .tx_din(tx_din_b), .tx_done(tx_done_b),
    .busy(busy_b), .grant_id(gid_b), .timeout_err(to_b)
  );

  // A request stays up while more raises than acks are outstanding.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_a[i] = (raised_a[i] != acked_a[i]);
      req_b[i] = (raised_b[i] != acked_b[i]);
    end
  end

  assign tx_done_a = mdone_a | sdone_a;
  assign tx_done_b = mdone_b;

  // Transmitter models: pulse tx_done dly cycles after tx_start (dly 0 = never).
  always @(posedge clk) begin
    if (reset_a) begin
      cnt_a <= 0; mdone_a <= 1'b0;
    end else if (tx_start_a) begin
      cnt_a <= (dly_a > 0) ? dly_a - 1 : 0; mdone_a <= (dly_a == 1);
    end else if (cnt_a != 0) begin
      cnt_a <= cnt_a - 1; mdone_a <= (cnt_a == 1);
    end else begin
      mdone_a <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (reset_b) begin
      cnt_b <= 0; mdone_b <= 1'b0;
    end else if (tx_start_b) begin
      cnt_b <= (dly_b > 0) ? dly_b - 1 : 0; mdone_b <= (dly_b == 1);
    end else if (cnt_b != 0) begin
      cnt_b <= cnt_b - 1; mdone_b <= (cnt_b == 1);
    end else begin
      mdone_b <= 1'b0;
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: every ack pops one expectation; latency measured from tx_start.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_start_a === 1'b1) st_a = cyc;
      if (tx_start_b === 1'b1) st_b = cyc;
      if (ack_a != 4'b0) begin
        if (q_a.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL a_unexpected_ack: got ack=%b grant=%0d expected no ack", ack_a, gid_a);
        end else begin
          em = q_a.pop_front();
          chk("a_ack", 32'(ack_a), 32'(em.ack));
          chk("a_grant_id", 32'(gid_a), 32'(em.gid));
          chk("a_tx_din", 32'(tx_din_a), 32'(em.din));
          chk("a_timeout_err", 32'(to_a), 32'(em.to));
          chk("a_latency", 32'(cyc - st_a), 32'(em.lat));
        end
        for (int i = 0; i < 4; i++) if (ack_a[i]) acked_a[i]++;
      end else if (to_a === 1'b1) begin
        n_checks++; n_fail++;
        $display("FAIL a_stray_timeout: got timeout_err=1 expected 0 without ack");
      end
      if (ack_b != 4'b0) begin
        if (q_b.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL b_unexpected_ack: got ack=%b grant=%0d expected no ack", ack_b, gid_b);
        end else begin
          em = q_b.pop_front();
          chk("b_ack", 32'(ack_b), 32'(em.ack));
          chk("b_grant_id", 32'(gid_b), 32'(em.gid));
          chk("b_tx_din", 32'(tx_din_b), 32'(em.din));
          chk("b_timeout_err", 32'(to_b), 32'(em.to));
          chk("b_latency", 32'(cyc - st_b), 32'(em.lat));
        end
        for (int i = 0; i < 4; i++) if (ack_b[i]) acked_b[i]++;
      end else if (to_b === 1'b1) begin
        n_checks++; n_fail++;
        $display("FAIL b_stray_timeout: got timeout_err=1 expected 0 without ack");
      end
    end
  end

  task automatic expect_tx(input int d, input logic [3:0] a, input logic [1:0] g,
                           input logic [7:0] v, input logic t, input int l);
    exp_t e;
    e.ack = a; e.gid = g; e.din = v; e.to = t; e.lat = l;
    if (d == 0) q_a.push_back(e);
    else q_b.push_back(e);
  endtask

  task automatic raise(input int d, input int i, input logic [7:0] v, input int n);
    if (d == 0) begin
      din_a[i*8 +: 8] = v; raised_a[i] += n;
    end else begin
      din_b[i*8 +: 8] = v; raised_b[i] += n;
    end
  endtask

  task automatic drain(input int d, input int max);
    int k = 0;
    while (((d == 0) ? q_a.size() : q_b.size()) != 0 && k < max) begin
      @(negedge clk);
      k++;
    end
    if (((d == 0) ? q_a.size() : q_b.size()) != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_%0d: got %0d pending acks after %0d cycles expected 0", d,
               (d == 0) ? q_a.size() : q_b.size(), max);
      if (d == 0) q_a.delete();
      else q_b.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_ack", 32'(ack_a), 32'd0);
    chk("rst_tx_start", 32'(tx_start_a), 32'd0);
    chk("rst_timeout_err", 32'(to_a), 32'd0);
    chk("rst_grant_id", 32'(gid_a), 32'd0);
    chk("rst_tx_din", 32'(tx_din_a), 32'd0);
    chk("rst_b_busy", 32'(busy_b), 32'd0);
    reset_a = 1'b0;
    reset_b = 1'b0;

    // tx_done with nothing pending leaves the arbiter idle.
    sdone_a = 1'b1;
    repeat (2) @(negedge clk);
    sdone_a = 1'b0;
    chk("idle_done_busy", 32'(busy_a), 32'd0);
    chk("idle_done_tx_start", 32'(tx_start_a), 32'd0);

    // All four requesting: rotation 0,1,2,3,0.
    dly_a = 3;
    expect_tx(0, 4'b0001, 2'd0, 8'hA0, 1'b0, 4);
    expect_tx(0, 4'b0010, 2'd1, 8'hA1, 1'b0, 4);
    expect_tx(0, 4'b0100, 2'd2, 8'hA2, 1'b0, 4);
    expect_tx(0, 4'b1000, 2'd3, 8'hA3, 1'b0, 4);
    expect_tx(0, 4'b0001, 2'd0, 8'hA0, 1'b0, 4);
    raise(0, 0, 8'hA0, 2);
    raise(0, 1, 8'hA1, 1);
    raise(0, 2, 8'hA2, 1);
    raise(0, 3, 8'hA3, 1);
    drain(0, 200);

    // ptr sits at 1: requester 3 wins over requester 0.
    expect_tx(0, 4'b1000, 2'd3, 8'h63, 1'b0, 4);
    expect_tx(0, 4'b0001, 2'd0, 8'h60, 1'b0, 4);
    raise(0, 0, 8'h60, 1);
    raise(0, 3, 8'h63, 1);
    drain(0, 100);

    // Single long transfer; din changes after grant must not reach tx_din.
    dly_a = 2170;
    expect_tx(0, 4'b0100, 2'd2, 8'h37, 1'b0, 2171);
    raise(0, 2, 8'h37, 1);
    @(negedge clk);
    chk("start_latency", 32'(tx_start_a), 32'd1);
    chk("start_tx_din", 32'(tx_din_a), 32'h37);
    chk("start_grant_id", 32'(gid_a), 32'd2);
    chk("start_busy", 32'(busy_a), 32'd1);
    din_a[23:16] = 8'hC4;
    @(negedge clk);
    chk("start_one_cycle", 32'(tx_start_a), 32'd0);
    drain(0, 3000);

    // tx_done during IDLE and START is ignored.
    dly_a = 5;
    expect_tx(0, 4'b0010, 2'd1, 8'h4D, 1'b0, 6);
    raise(0, 1, 8'h4D, 1);
    sdone_a = 1'b1;
    @(negedge clk);
    chk("startdone_tx_start", 32'(tx_start_a), 32'd1);
    chk("startdone_grant_id", 32'(gid_a), 32'd1);
    @(negedge clk);
    sdone_a = 1'b0;
    chk("startdone_busy", 32'(busy_a), 32'd1);
    chk("startdone_no_ack", 32'(ack_a), 32'd0);
    drain(0, 100);

    // Reset during BUSY aborts silently; pending requests restart from index 0.
    dly_a = 20;
    expect_tx(0, 4'b0010, 2'd1, 8'h5B, 1'b0, 21);
    expect_tx(0, 4'b1000, 2'd3, 8'h5C, 1'b0, 21);
    raise(0, 1, 8'h5B, 1);
    raise(0, 3, 8'h5C, 1);
    repeat (5) @(negedge clk);
    chk("pre_reset_grant_id", 32'(gid_a), 32'd3);
    reset_a = 1'b1;
    @(negedge clk);
    reset_a = 1'b0;
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_ack", 32'(ack_a), 32'd0);
    chk("abort_grant_id", 32'(gid_a), 32'd0);
    chk("abort_tx_din", 32'(tx_din_a), 32'd0);
    @(negedge clk);
    chk("regrant_tx_start", 32'(tx_start_a), 32'd1);
    chk("regrant_grant_id", 32'(gid_a), 32'd1);
    drain(0, 200);

    // Short watchdog: timeout, completion on the last count, late done, normal.
    dly_b = 0;
    expect_tx(1, 4'b0001, 2'd0, 8'h11, 1'b1, 17);
    raise(1, 0, 8'h11, 1);
    drain(1, 100);
    dly_b = 16;
    expect_tx(1, 4'b0010, 2'd1, 8'h22, 1'b0, 17);
    raise(1, 1, 8'h22, 1);
    drain(1, 100);
    dly_b = 17;
    expect_tx(1, 4'b0100, 2'd2, 8'h33, 1'b1, 17);
    raise(1, 2, 8'h33, 1);
    drain(1, 100);
    dly_b = 3;
    expect_tx(1, 4'b1000, 2'd3, 8'h44, 1'b0, 4);
    raise(1, 3, 8'h44, 1);
    drain(1, 100);
    chk("final_b_busy", 32'(busy_b), 32'd0);
    chk("final_a_busy", 32'(busy_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
